// File: rtl/sram_arbiter.sv
// Two-port (A = CPU, B = loader/DMA) arbiter and setup/strobe/hold sequencer for an async SRAM.
// Latency: ack STROBE_CYCLES+2 cycles after a req is seen in IDLE; one access in flight at a time.
// Backpressure: a req is held until its ack pulses; a losing port simply waits, with no timeout.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, A beats B).
module sram_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int STROBE_CYCLES = 1   // 1..15, the strobe counter is 4 bits wide
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  aReq,
  input  logic                  aWe,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aWData,
  output logic                  aAck,
  output logic [DATA_WIDTH-1:0] aRData,
  input  logic                  bReq,
  input  logic                  bWe,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bWData,
  output logic                  bAck,
  output logic [DATA_WIDTH-1:0] bRData,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  inout  wire  [DATA_WIDTH-1:0] sramData,
  output logic                  sramNotCS,
  output logic                  sramNotOE,
  output logic                  sramNotWE,
  output logic                  grantB
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counter value on the final STROBE cycle.
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   grant_b_q, grant_b_d;
  logic                   acc_we_q, acc_we_d;
  logic [ADDR_WIDTH-1:0]  acc_addr_q, acc_addr_d;
  logic [DATA_WIDTH-1:0]  acc_wdata_q, acc_wdata_d;
  logic                   cs_n_q, cs_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   drive_q, drive_d;
  logic                   a_ack_q, a_ack_d;
  logic                   b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0]  a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]  b_rdata_q, b_rdata_d;
  logic                   pick_b;
  logic                   any_req;
  logic                   strobe_done;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Set when B should win the next tie, i.e. A was granted last. Cleared by reset so A wins first.
  logic                   prefer_b_q, prefer_b_d;
`endif

  assign any_req     = aReq | bReq;
  assign strobe_done = (state_q == ST_STROBE) && (cnt_q == STROBE_LAST);

  // Winner selection; only consumed in IDLE. A lone requester always wins.
  always_comb begin
    pick_b = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    if (aReq && bReq) begin
      pick_b = prefer_b_q;
    end else begin
      pick_b = bReq;
    end
`else
    pick_b = bReq & ~aReq;
`endif
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Tie-break pointer flips to the other port whenever a grant is made.
  always_comb begin
    prefer_b_d = prefer_b_q;
    if ((state_q == ST_IDLE) && any_req) begin
      prefer_b_d = ~pick_b;
    end
  end

  // Tie-break pointer register.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end
`endif

  // Sequencer next state; the winner's request is captured on the IDLE->SETUP edge
  // so later changes (or an early drop) of req/we/addr/wdata cannot disturb the access.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_b_d   = grant_b_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_SETUP;
          grant_b_d   = pick_b;
          acc_we_d    = pick_b ? bWe    : aWe;
          acc_addr_d  = pick_b ? bAddr  : aAddr;
          acc_wdata_d = pick_b ? bWData : aWData;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 4'd0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SRAM strobes, bus enable and acks are decoded from the next state so that every
  // one of them comes straight out of a flop and changes in step with the state.
  always_comb begin
    cs_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    case (state_d)
      ST_SETUP: begin
        cs_n_d  = 1'b0;
        oe_n_d  = acc_we_d;
        drive_d = acc_we_d;
      end
      ST_STROBE: begin
        cs_n_d  = 1'b0;
        oe_n_d  = acc_we_d;
        we_n_d  = ~acc_we_d;
        drive_d = acc_we_d;
      end
      ST_HOLD: begin
        // WE already back high; write data stays on the bus for hold time.
        cs_n_d  = 1'b0;
        drive_d = acc_we_d;
        a_ack_d = ~grant_b_d;
        b_ack_d = grant_b_d;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // Read data is captured on the edge that closes the last STROBE cycle, while OE is still low.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (strobe_done && !acc_we_q) begin
      if (grant_b_q) begin
        b_rdata_d = sramData;
      end else begin
        a_rdata_d = sramData;
      end
    end
  end

  // State and access registers; reset abandons any access in flight without an ack.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      grant_b_q   <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_b_q   <= grant_b_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
    end
  end

  // Registered SRAM controls, bus enable, acks and per-port read data.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      cs_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      cs_n_q    <= cs_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // The arbiter only drives the bus during write accesses; OE is never low at the same time.
  assign sramData  = drive_q ? acc_wdata_q : {DATA_WIDTH{1'bz}};

  assign sramAddr  = acc_addr_q;
  assign sramNotCS = cs_n_q;
  assign sramNotOE = oe_n_q;
  assign sramNotWE = we_n_q;
  assign grantB    = grant_b_q;
  assign aAck      = a_ack_q;
  assign bAck      = b_ack_q;
  assign aRData    = a_rdata_q;
  assign bRData    = b_rdata_q;

endmodule
